// File: rtl/uart_baud_pkg.sv
// Shared constants for the UART baud generator and the tx/rx blocks that consume its ticks.
package uart_baud_pkg;

  localparam int unsigned DIV_MIN           = 2;
  localparam int unsigned BAUD_CNT_W        = 16;
  localparam int unsigned BAUD_FRAC_W       = 4;
  localparam int unsigned BAUD_OVERSAMPLE   = 16;
  // 50 MHz / 19200 / 16 = 162.76 -> 162 + 12/16
  localparam int unsigned BAUD_DEFAULT_INT  = 162;
  localparam int unsigned BAUD_DEFAULT_FRAC = 12;

  localparam int unsigned TICK_W            = 1;
  localparam int unsigned BIT_MID_OS        = BAUD_OVERSAMPLE / 2;

  function automatic int unsigned os_cnt_width(input int unsigned os);
    return (os < 2) ? 1 : $clog2(os);
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Divisor programming and tick outputs of the baud generator.
interface uart_baud_gen_if
  import uart_baud_pkg::*;
#(
  parameter int unsigned CNT_W  = BAUD_CNT_W,
  parameter int unsigned FRAC_W = BAUD_FRAC_W
);

  logic              en;
  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              div_pending;
  logic              cfg_err;
  logic              os_tick;
  logic              bit_tick;

  modport master (
    output en, div_int, div_frac, div_load,
    input  div_pending, cfg_err, os_tick, bit_tick
  );

  modport slave (
    input  en, div_int, div_frac, div_load,
    output div_pending, cfg_err, os_tick, bit_tick
  );

endinterface

// File: rtl/uart_frac_acc.sv
// Fractional-N accumulator: carry stretches the current oversample period by one cycle.
module uart_frac_acc
  import uart_baud_pkg::*;
#(
  parameter int unsigned FRAC_W = BAUD_FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, frac};
  assign carry = sum[FRAC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (advance) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable oversample/bit tick generator with glitch-free divisor reload.
// Fractional divisor support is built only when UART_BAUD_FRAC_EN is defined.
module uart_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned CNT_W        = BAUD_CNT_W,
  parameter int unsigned FRAC_W       = BAUD_FRAC_W,
  parameter int unsigned OVERSAMPLE   = BAUD_OVERSAMPLE,
  parameter int unsigned DEFAULT_INT  = BAUD_DEFAULT_INT,
  parameter int unsigned DEFAULT_FRAC = BAUD_DEFAULT_FRAC
) (
  input logic            clk,
  input logic            reset,
  uart_baud_gen_if.slave bus
);

  localparam int unsigned OS_W = os_cnt_width(OVERSAMPLE);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_int;
  logic [CNT_W-1:0] pend_int;
  logic [OS_W-1:0]  os_cnt;
  logic             pending;
  logic             cfg_err;
  logic             load_ok;
  logic             apply;
  logic             os_tick;
  logic [CNT_W:0]   period;

  assign load_ok = bus.div_load && (bus.div_int >= CNT_W'(DIV_MIN));
  // One extra bit so a maximal divisor plus carry still compares correctly.
  assign os_tick = bus.en && ({1'b0, cnt} == (period - (CNT_W+1)'(1)));
  // With en low the counter is idle, so a pending divisor can go in at once.
  assign apply   = pending && (os_tick || !bus.en);

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] active_frac;
  logic [FRAC_W-1:0] pend_frac;
  logic              carry;

  uart_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   (!bus.en || apply),
    .advance (os_tick),
    .frac    (active_frac),
    .carry   (carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_frac <= FRAC_W'(DEFAULT_FRAC);
      pend_frac   <= '0;
    end else begin
      if (apply)   active_frac <= pend_frac;
      if (load_ok) pend_frac   <= bus.div_frac;
    end
  end

  assign period = {1'b0, active_int} + (CNT_W+1)'(carry);
`else
  logic unused_frac;
  assign unused_frac = ^{bus.div_frac, FRAC_W'(DEFAULT_FRAC)};
  assign period      = {1'b0, active_int};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      os_cnt     <= '0;
      active_int <= CNT_W'(DEFAULT_INT);
      pend_int   <= '0;
      pending    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= bus.div_load && !load_ok;

      if (!bus.en) begin
        cnt    <= '0;
        os_cnt <= '0;
      end else if (os_tick) begin
        cnt    <= '0;
        os_cnt <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
      end else begin
        cnt    <= cnt + CNT_W'(1);
      end

      if (apply) active_int <= pend_int;

      // A load in the applying cycle re-arms pending with the newer value.
      if (load_ok) begin
        pend_int <= bus.div_int;
        pending  <= 1'b1;
      end else if (apply) begin
        pending  <= 1'b0;
      end
    end
  end

  assign bus.os_tick     = os_tick;
  assign bus.bit_tick    = os_tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
  assign bus.div_pending = pending;
  assign bus.cfg_err     = cfg_err;

endmodule
